// File: rtl/load_store_issue_arbiter_pkg.sv
// Shared types and default configuration for the load/store issue arbiter.
//   lsq_arb_state_t : arbiter FSM state encoding
//   DEFAULT_*       : default depth / starvation / outstanding-store limits
package load_store_issue_arbiter_pkg;

  typedef enum logic [1:0] {
    NORMAL        = 2'd0,
    CONFLICT_WAIT = 2'd1,
    FENCE_DRAIN   = 2'd2
  } lsq_arb_state_t;

  localparam int unsigned DEFAULT_SQ_DEPTH               = 4;
  localparam int unsigned DEFAULT_STARVE_LIMIT           = 8;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING_STORES = 4;

endpackage

// File: rtl/lsq_arb_perf_counters.sv
// Performance counters for the load/store issue arbiter.
// Only built when LSQ_ARB_PERF_EN is defined; otherwise the arbiter ties its
// perf outputs to zero and this module does not exist.
//   clk, rst        : clock, synchronous active-high reset
//   conflict_stall  : arbiter spent this cycle waiting on a store conflict
//   forced_store    : a store was popped because loads had starved it
//   conflict_stalls : 32-bit wrapping count of conflict_stall cycles
//   forced_stores   : 32-bit wrapping count of forced_store events
`ifdef LSQ_ARB_PERF_EN
module lsq_arb_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        conflict_stall,
  input  logic        forced_store,
  output logic [31:0] conflict_stalls,
  output logic [31:0] forced_stores
);

  logic [31:0] stalls_q, stalls_d;
  logic [31:0] forced_q, forced_d;

  always_comb begin
    stalls_d = stalls_q;
    forced_d = forced_q;
    if (conflict_stall) stalls_d = stalls_q + 32'd1;
    if (forced_store)   forced_d = forced_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stalls_q <= '0;
      forced_q <= '0;
    end else begin
      stalls_q <= stalls_d;
      forced_q <= forced_d;
    end
  end

  assign conflict_stalls = stalls_q;
  assign forced_stores   = forced_q;

endmodule
`endif

// File: rtl/load_store_issue_arbiter.sv
// Load/store issue arbiter: shares the single memory-subunit issue port between
// the load path and the store-queue head.
//  - Loads flagged as conflicting wait until the store they depend on reaches
//    the head of the store queue (or the queue empties).
//  - A ready store that keeps losing to loads is forced after STARVE_LIMIT losses.
//  - A fence drains all stores (issued and acknowledged) and pulses fence_done.
// Optional feature: define LSQ_ARB_PERF_EN to build the perf counters; otherwise
// perf_conflict_stalls / perf_forced_stores read as zero.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   load_valid/_conflict/_sq_index, load_ready : load request and acceptance
//   sq_valid, sq_empty, sq_oldest, sq_pop     : store-queue head interface
//   mem_valid, mem_is_store, mem_ready        : memory-subunit request
//   mem_store_ack             : one previously issued store completed
//   fence_req, fence_done     : fence level request / one-cycle completion pulse
//   perf_conflict_stalls, perf_forced_stores  : performance counters
module load_store_issue_arbiter
  import load_store_issue_arbiter_pkg::*;
#(
  parameter int unsigned SQ_DEPTH               = DEFAULT_SQ_DEPTH,
  parameter int unsigned STARVE_LIMIT           = DEFAULT_STARVE_LIMIT,
  parameter int unsigned MAX_OUTSTANDING_STORES = DEFAULT_MAX_OUTSTANDING_STORES,
  localparam int unsigned LOG2_SQ_DEPTH = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic                     load_conflict,
  input  logic [LOG2_SQ_DEPTH-1:0] load_sq_index,
  output logic                     load_ready,
  input  logic                     sq_valid,
  input  logic                     sq_empty,
  input  logic [LOG2_SQ_DEPTH-1:0] sq_oldest,
  output logic                     sq_pop,
  output logic                     mem_valid,
  output logic                     mem_is_store,
  input  logic                     mem_ready,
  input  logic                     mem_store_ack,
  input  logic                     fence_req,
  output logic                     fence_done,
  output logic [31:0]              perf_conflict_stalls,
  output logic [31:0]              perf_forced_stores
);

  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING_STORES + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [OUT_W-1:0]    MAX_OUT    = OUT_W'(MAX_OUTSTANDING_STORES);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  lsq_arb_state_t             state_q, state_d;
  logic [LOG2_SQ_DEPTH-1:0]   wait_index_q, wait_index_d;
  logic [STARVE_W-1:0]        starve_q, starve_d;
  logic [OUT_W-1:0]           outstanding_q, outstanding_d;
  // A request left pending by mem_ready=0 is re-presented unchanged next cycle.
  logic                       lock_q, lock_d;
  logic                       lock_store_q, lock_store_d;

  logic load_grant, store_grant;
  logic store_ok, conflict_clear;

  assign store_ok       = sq_valid && (outstanding_q < MAX_OUT);
  assign conflict_clear = sq_empty || (sq_oldest == wait_index_q);

  always_comb begin
    load_grant   = 1'b0;
    store_grant  = 1'b0;
    fence_done   = 1'b0;
    state_d      = state_q;
    wait_index_d = wait_index_q;

    if (lock_q) begin
      load_grant  = !lock_store_q && load_valid;
      store_grant = lock_store_q && sq_valid;
    end

    case (state_q)
      NORMAL: begin
        // While a request is locked, arbitration and state changes wait for it.
        if (!lock_q) begin
          if (load_valid && load_conflict) begin
            // Never pop the store the load waits on, or the wait could not clear.
            store_grant  = store_ok && (sq_oldest != load_sq_index);
            state_d      = CONFLICT_WAIT;
            wait_index_d = load_sq_index;
          end else if (fence_req) begin
            store_grant = store_ok;
            state_d     = FENCE_DRAIN;
          end else if (store_ok && (starve_q == STARVE_MAX)) begin
            store_grant = 1'b1;
          end else if (load_valid) begin
            load_grant = 1'b1;
          end else begin
            store_grant = store_ok;
          end
        end
      end
      CONFLICT_WAIT: begin
        if (!lock_q) begin
          if (conflict_clear) begin
            load_grant = load_valid;
          end else begin
            store_grant = store_ok && (sq_oldest != wait_index_q);
          end
        end
        if (load_grant && mem_ready) state_d = NORMAL;
      end
      FENCE_DRAIN: begin
        if (!lock_q) store_grant = store_ok;
        if (sq_empty && (outstanding_q == '0) && !mem_store_ack && !store_grant) begin
          fence_done = 1'b1;
          state_d    = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  assign mem_valid    = load_grant || store_grant;
  assign mem_is_store = store_grant;
  assign sq_pop       = store_grant && mem_ready;
  assign load_ready   = load_grant && mem_ready;

  assign lock_d       = mem_valid && !mem_ready;
  assign lock_store_d = store_grant;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({sq_pop, mem_store_ack})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Counts loads that won while a store was eligible; saturates at STARVE_LIMIT.
  always_comb begin
    starve_d = starve_q;
    if (sq_pop || !sq_valid) begin
      starve_d = '0;
    end else if (store_ok && load_ready && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= NORMAL;
      wait_index_q  <= '0;
      starve_q      <= '0;
      outstanding_q <= '0;
      lock_q        <= 1'b0;
      lock_store_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_index_q  <= wait_index_d;
      starve_q      <= starve_d;
      outstanding_q <= outstanding_d;
      lock_q        <= lock_d;
      lock_store_q  <= lock_store_d;
    end
  end

`ifdef LSQ_ARB_PERF_EN
  lsq_arb_perf_counters u_perf (
    .clk             (clk),
    .rst             (rst),
    .conflict_stall  (state_q == CONFLICT_WAIT),
    .forced_store    (sq_pop && (starve_q == STARVE_MAX)),
    .conflict_stalls (perf_conflict_stalls),
    .forced_stores   (perf_forced_stores)
  );
`else
  assign perf_conflict_stalls = '0;
  assign perf_forced_stores   = '0;
`endif

  a_ack_underflow : assert property (@(posedge clk) disable iff (rst)
    mem_store_ack |-> (outstanding_q != '0));

  a_pop_needs_valid : assert property (@(posedge clk) disable iff (rst)
    sq_pop |-> sq_valid);

  a_load_held : assert property (@(posedge clk) disable iff (rst)
    (load_valid && !load_ready) |=> load_valid);

endmodule

// File: tb/tb_load_store_issue_arbiter.sv
module tb_load_store_issue_arbiter;

  // Expected output patterns: {load_ready, sq_pop, mem_valid, mem_is_store, fence_done}
  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] LD   = 5'b10100;
  localparam logic [4:0] LDW  = 5'b00100;
  localparam logic [4:0] ST   = 5'b01110;
  localparam logic [4:0] STW  = 5'b00110;
  localparam logic [4:0] FD   = 5'b00001;

`ifdef LSQ_ARB_PERF_EN
  localparam logic [31:0] EXP_STALLS = 32'd7;
  localparam logic [31:0] EXP_FORCED = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_FORCED = 32'd0;
`endif

  typedef struct {
    logic       lv;
    logic       lc;
    logic [1:0] li;
    logic       sv;
    logic       se;
    logic [1:0] so;
    logic       mr;
    logic       ack;
    logic       fr;
    logic [4:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_conflict, load_ready;
  logic [1:0]  load_sq_index, sq_oldest;
  logic        sq_valid, sq_empty, sq_pop;
  logic        mem_valid, mem_is_store, mem_ready, mem_store_ack;
  logic        fence_req, fence_done;
  logic [31:0] perf_conflict_stalls, perf_forced_stores;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_seen = 0;
  vec_t tbl[$];
  vec_t fence_tbl[$];

  always #5 clk = ~clk;

  load_store_issue_arbiter #(
    .SQ_DEPTH               (4),
    .STARVE_LIMIT           (8),
    .MAX_OUTSTANDING_STORES (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .load_valid           (load_valid),
    .load_conflict        (load_conflict),
    .load_sq_index        (load_sq_index),
    .load_ready           (load_ready),
    .sq_valid             (sq_valid),
    .sq_empty             (sq_empty),
    .sq_oldest            (sq_oldest),
    .sq_pop               (sq_pop),
    .mem_valid            (mem_valid),
    .mem_is_store         (mem_is_store),
    .mem_ready            (mem_ready),
    .mem_store_ack        (mem_store_ack),
    .fence_req            (fence_req),
    .fence_done           (fence_done),
    .perf_conflict_stalls (perf_conflict_stalls),
    .perf_forced_stores   (perf_forced_stores)
  );

  function automatic vec_t mk(logic lv, logic lc, logic [1:0] li, logic sv, logic se,
                              logic [1:0] so, logic mr, logic ack, logic fr,
                              logic [4:0] exp);
    vec_t v;
    v.lv = lv; v.lc = lc; v.li = li; v.sv = sv; v.se = se; v.so = so;
    v.mr = mr; v.ack = ack; v.fr = fr; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    load_valid    = v.lv;
    load_conflict = v.lc;
    load_sq_index = v.li;
    sq_valid      = v.sv;
    sq_empty      = v.se;
    sq_oldest     = v.so;
    mem_ready     = v.mr;
    mem_store_ack = v.ack;
    fence_req     = v.fr;
  endtask

  // Called just after a rising edge: drive, check at the falling edge, advance.
  task automatic apply(input vec_t v, input string name, input int idx);
    logic [4:0] act;
    drive(v);
    @(negedge clk);
    act = {load_ready, sq_pop, mem_valid, mem_is_store, fence_done};
    if (fence_done) fd_seen++;
    n_tests++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got {lr,pop,mv,st,fd}=%b expected %b", name, idx, act, v.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // Main table: consecutive cycles from reset, respecting the load-hold protocol.
    //                 lv lc li sv se so mr ack fr exp
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, IDLE));  // reset state
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, LD));    // lone load
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, ST));    // lone store, out=1
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, LD));    // load beats store, starve=1
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 0, LDW));   // backpressure, ack -> out=0
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, LD));    // held load completes
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, STW));   // store waits on mem_ready
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, ST));    // held store keeps port, out=1
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 1, 1, 0, LD));    // load now, ack -> out=0
    tbl.push_back(mk(1, 1, 2, 1, 0, 0, 1, 0, 0, ST));    // conflict idx2; pop 0, out=1
    tbl.push_back(mk(1, 1, 2, 1, 0, 1, 1, 0, 1, ST));    // wait; pop 1; fence ignored
    tbl.push_back(mk(1, 1, 2, 1, 0, 2, 1, 0, 0, LD));    // head==2: load before store 2
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 0, ST));    // store 2, ack, out=2
    tbl.push_back(mk(1, 1, 1, 1, 0, 3, 1, 1, 0, ST));    // wrap conflict idx1; pop 3
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, 0, ST));    // pop 0
    tbl.push_back(mk(1, 1, 1, 1, 0, 1, 1, 0, 0, LD));    // head==1: load
    tbl.push_back(mk(1, 1, 3, 1, 0, 2, 0, 0, 0, STW));   // conflict idx3, store stalls
    tbl.push_back(mk(1, 1, 3, 1, 0, 2, 1, 0, 0, ST));    // held store issues, out=3
    tbl.push_back(mk(1, 1, 3, 0, 1, 0, 0, 0, 0, LDW));   // cleared by sq_empty
    tbl.push_back(mk(1, 1, 3, 0, 1, 0, 1, 1, 0, LD));    // load done, out=2
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, ST));    // out=3
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, ST));    // out=4
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 0, IDLE));  // limit reached
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 0, IDLE));  // ack only, out=3
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 0, ST));    // pop+ack, out stays 3
    tbl.push_back(mk(0, 0, 0, 1, 0, 3, 1, 0, 0, ST));    // out=4
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, IDLE));  // limit reached again
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, IDLE));

    // Fence with three queued stores, acks arriving five cycles after issue.
    fence_tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 1, ST));
    fence_tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 1, ST));
    fence_tbl.push_back(mk(1, 0, 0, 1, 0, 2, 1, 0, 1, ST));
    fence_tbl.push_back(mk(1, 0, 0, 0, 1, 3, 1, 0, 1, IDLE));
    fence_tbl.push_back(mk(1, 0, 0, 0, 1, 3, 1, 0, 1, IDLE));
    for (int i = 0; i < 3; i++) fence_tbl.push_back(mk(1, 0, 0, 0, 1, 3, 1, 1, 1, IDLE));
    fence_tbl.push_back(mk(1, 0, 0, 0, 1, 3, 1, 0, 1, FD));
    fence_tbl.push_back(mk(1, 0, 0, 0, 1, 3, 1, 0, 0, LD));
    fence_tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0, 0, IDLE));

    drive(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, IDLE));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check32("reset_perf_stalls", perf_conflict_stalls, 32'd0);
    check32("reset_perf_forced", perf_forced_stores, 32'd0);

    foreach (tbl[i]) apply(tbl[i], "table", i);

    // Starvation: forced store after 8 load wins; sq_valid low clears the count.
    for (int i = 0; i < 25; i++) begin
      apply(mk(1, 0, 0, (i != 14), (i == 14), 0, 1, 0, 0,
               ((i == 8) || (i == 23)) ? ST : LD), "starve", i);
    end
    for (int i = 0; i < 2; i++) apply(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, IDLE), "drain", i);

    fd_seen = 0;
    foreach (fence_tbl[i]) apply(fence_tbl[i], "fence", i);
    n_tests++;
    if (fd_seen != 1) begin
      n_fail++;
      $display("FAIL fence_pulse_count: got %0d expected 1", fd_seen);
    end

    check32("perf_stalls", perf_conflict_stalls, EXP_STALLS);
    check32("perf_forced", perf_forced_stores, EXP_FORCED);

    // Reset in the middle of a fence with a store held by backpressure.
    apply(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, ST), "rst_fence", 0);
    apply(mk(0, 0, 0, 1, 0, 1, 0, 0, 1, STW), "rst_fence", 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check32("rst_perf_stalls", perf_conflict_stalls, 32'd0);
    check32("rst_perf_forced", perf_forced_stores, 32'd0);
    apply(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, LD), "rst_normal", 0);
    for (int i = 0; i < 4; i++) begin
      apply(mk(0, 0, 0, 1, 0, 2'(i), 1, 0, 0, ST), "rst_outstanding", i);
    end
    apply(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, IDLE), "rst_outstanding", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
